load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, meaning the byte size of the attached data memory.
REQ-002 SHALL have port Clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-004 SHALL have port ReqValid, input, 1, meaning the pipeline presents a memory request.
REQ-005 SHALL have port ReqReady, output, 1, meaning the unit accepts the request this cycle.
REQ-006 SHALL have port ReqWrite, input, 1, meaning 1 = store, 0 = load.
REQ-007 SHALL have port ReqByte, input, 1, meaning 1 = byte access, 0 = 16-bit word access.
REQ-008 SHALL have port ReqSigned, input, 1, meaning a byte load is sign-extended (1) or zero-extended (0).
REQ-009 SHALL have port ReqAddr, input, 16, meaning the byte address.
REQ-010 SHALL have port ReqWData, input, 16, meaning the store data; a byte store uses bits [7:0].
REQ-011 SHALL have port RspValid, output, 1, meaning a one-cycle response pulse.
REQ-012 SHALL have port RspData, output, 16, meaning the load result; 0 for stores and faults.
REQ-013 SHALL have port RspFault, output, 1, meaning the address was out of range (or misaligned, see REQ-030).
REQ-014 SHALL have port MemAddress, output, 16, meaning the data-memory byte address.
REQ-015 SHALL have port MemWriteData, output, 16, meaning the big-endian word to memory.
REQ-016 SHALL have port MemWrite, output, 1, meaning the memory write strobe, sampled by memory on the rising Clock edge.
REQ-017 SHALL have port MemRead, output, 1, meaning the memory read enable.
REQ-018 SHALL have port MemReadData, input, 16, meaning combinational read data: [15:8] = byte[addr] and [7:0] = byte[addr+1].

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RMW_WRITE and RESP.
REQ-020 SHALL assert ReqReady only in IDLE; a request is accepted when ReqValid and ReqReady are both 1, and the request fields are registered at acceptance.
REQ-021 SHALL treat a request as faulting when ReqAddr > MEM_BYTES-2 (the memory always touches addr and addr+1).
REQ-022 SHALL handle an accepted fault as IDLE->RESP, with RspFault=1, RspData=0, and no MemRead/MemWrite pulse; latency is 1 cycle.
REQ-023 SHALL handle a word load as IDLE->ACCESS->RESP: in ACCESS, MemRead=1 and MemAddress=addr, and MemReadData is captured; in RESP, RspData = the captured word; latency is 2 cycles.
REQ-024 SHALL handle a byte load like a word load, except RspData = captured[15:8], sign-extended or zero-extended to 16 bits per ReqSigned.
REQ-025 SHALL handle a word store as IDLE->ACCESS->RESP: in ACCESS, MemWrite=1 and MemWriteData=ReqWData; latency is 2 cycles.
REQ-026 SHALL handle a byte store as read-modify-write, IDLE->ACCESS->RMW_WRITE->RESP: ACCESS reads and captures the word; RMW_WRITE writes {ReqWData[7:0], captured[7:0]}, so byte addr+1 is preserved; latency is 3 cycles.
REQ-027 SHALL go RESP->IDLE unconditionally, with RspValid high for exactly 1 cycle and no response backpressure.
REQ-028 SHALL drive MemWrite and MemRead combinationally from state only; MemAddress holds the registered address outside IDLE and is 0 in IDLE.

Reset
REQ-029 SHALL, while Reset_n=0, immediately force state=IDLE, ReqReady=1 after release, RspValid=0, RspData=0, RspFault=0, MemWrite=0, MemRead=0, MemAddress=0 and MemWriteData=0; a reset during ACCESS or RMW_WRITE aborts the operation with no write and no response.

Configuration
REQ-030 SHALL support the macro LSU_ALIGN_CHECK_EN: when defined, a word access with ReqAddr[0]=1 faults per REQ-022; when undefined, odd word addresses are legal and behave per REQ-023/REQ-025.

Structure
REQ-031 SHALL place the FSM state enum, the default MEM_BYTES constant and the access-type encodings in the shared package lsu_pkg.
REQ-032 SHALL place the combinational byte extract/extend and byte-merge logic in the single sub-module lsu_data_align.

Verification
REQ-033 SHALL cover a word load: memory bytes [0x10]=0xAB, [0x11]=0xCD; load word at 0x10 -> RspValid 2 cycles after acceptance with RspData=0xABCD and RspFault=0.
REQ-034 SHALL cover byte loads: byte [0x20]=0x80; signed byte load -> 0xFF80; unsigned byte load -> 0x0080.
REQ-035 SHALL cover a byte store: [0x30]=0x12, [0x31]=0x34; byte store of 0x00EE at 0x30 -> memory becomes [0x30]=0xEE, [0x31]=0x34, RspValid at +3 cycles, and exactly one MemWrite pulse.
REQ-036 SHALL cover faults: MEM_BYTES=128, store at 0x7F -> RspFault=1 at +1 cycle with zero MemWrite/MemRead pulses; with LSU_ALIGN_CHECK_EN defined, a word load at 0x11 -> fault.
REQ-037 SHALL cover reset mid-operation: Reset_n low during RMW_WRITE -> MemWrite=0 at once, memory unchanged, no RspValid, and ReqReady=1 after release.
REQ-038 SHALL cover back-to-back requests: ReqValid held high for 3 requests -> each is accepted only in IDLE and the responses arrive in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Purpose: shared types and constants for the load/store unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package lsu_pkg;

  // Default data-memory size in bytes.
  localparam int LSU_MEM_BYTES_DEFAULT = 128;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    RMW_WRITE = 2'd2,
    RESP      = 2'd3
  } lsu_state_e;

  // Access type: bit 1 = store, bit 0 = byte access.
  typedef enum logic [1:0] {
    ACC_LOAD_WORD  = 2'b00,
    ACC_LOAD_BYTE  = 2'b01,
    ACC_STORE_WORD = 2'b10,
    ACC_STORE_BYTE = 2'b11
  } lsu_acc_e;

  // Build the access type from the request direction and size bits.
  function automatic lsu_acc_e acc_encode(input logic is_write, input logic is_byte);
    return lsu_acc_e'({is_write, is_byte});
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Purpose: byte extract/extend for loads and byte merge for read-modify-write stores.
// Latency: combinational.
// Backpressure: none.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [15:0] word_in,
  input  logic        is_signed,
  input  logic [7:0]  store_byte,
  output logic [15:0] load_byte_ext,
  output logic [15:0] merged_word
);

  // Big-endian memory word: byte[addr] lives in [15:8], byte[addr+1] in [7:0].
  always_comb begin
    load_byte_ext = {{8{is_signed & word_in[15]}}, word_in[15:8]};
    merged_word   = {store_byte, word_in[7:0]};
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: single-outstanding load/store unit for a 16-bit big-endian data memory; macro LSU_ALIGN_CHECK_EN faults odd word addresses.
// Latency: fault 1 cycle, word load/store and byte load 2 cycles, byte store (read-modify-write) 3 cycles.
// Backpressure: ReqReady only in IDLE; the response is a one-cycle pulse with no backpressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic        ReqByte,
  input  logic        ReqSigned,
  input  logic [15:0] ReqAddr,
  input  logic [15:0] ReqWData,
  output logic        RspValid,
  output logic [15:0] RspData,
  output logic        RspFault,
  output logic [15:0] MemAddress,
  output logic [15:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [15:0] MemReadData
);

  lsu_state_e  state_q, state_d;
  lsu_acc_e    acc_q, acc_d;
  logic        signed_q, signed_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_fault_q, rsp_fault_d;

  logic [31:0] req_addr_ext;
  logic        req_fault;
  logic [15:0] align_word;
  logic [15:0] load_byte_ext;
  logic [15:0] merged_word;

  // Range check (the memory always touches addr and addr+1), plus optional alignment check.
  always_comb begin
    req_addr_ext = {16'd0, ReqAddr};
    req_fault    = (req_addr_ext > 32'(MEM_BYTES - 2));
`ifdef LSU_ALIGN_CHECK_EN
    if (!ReqByte && ReqAddr[0]) begin
      req_fault = 1'b1;
    end
`endif
  end

  // Live read data during ACCESS, captured word afterwards for the merge.
  always_comb begin
    align_word = (state_q == ACCESS) ? MemReadData : cap_q;
  end

  lsu_data_align u_align (
    .word_in       (align_word),
    .is_signed     (signed_q),
    .store_byte    (wdata_q[7:0]),
    .load_byte_ext (load_byte_ext),
    .merged_word   (merged_word)
  );

  // Next-state and next-response computation.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cap_d       = cap_q;
    rsp_data_d  = 16'd0;
    rsp_vld_d   = 1'b0;
    rsp_fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          acc_d    = acc_encode(ReqWrite, ReqByte);
          signed_d = ReqSigned;
          addr_d   = ReqAddr;
          wdata_d  = ReqWData;
          if (req_fault) begin
            state_d     = RESP;
            rsp_vld_d   = 1'b1;
            rsp_fault_d = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cap_d = MemReadData;
        case (acc_q)
          ACC_LOAD_WORD: begin
            state_d    = RESP;
            rsp_vld_d  = 1'b1;
            rsp_data_d = MemReadData;
          end
          ACC_LOAD_BYTE: begin
            state_d    = RESP;
            rsp_vld_d  = 1'b1;
            rsp_data_d = load_byte_ext;
          end
          ACC_STORE_WORD: begin
            state_d   = RESP;
            rsp_vld_d = 1'b1;
          end
          default: begin
            state_d = RMW_WRITE;
          end
        endcase
      end
      RMW_WRITE: begin
        state_d   = RESP;
        rsp_vld_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All controller state and registered response outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      acc_q       <= ACC_LOAD_WORD;
      signed_q    <= 1'b0;
      addr_q      <= 16'd0;
      wdata_q     <= 16'd0;
      cap_q       <= 16'd0;
      rsp_data_q  <= 16'd0;
      rsp_vld_q   <= 1'b0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Memory strobes and data decoded from the current state so reset kills them at once.
  always_comb begin
    ReqReady     = (state_q == IDLE);
    MemRead      = (state_q == ACCESS) && (acc_q != ACC_STORE_WORD);
    MemWrite     = ((state_q == ACCESS) && (acc_q == ACC_STORE_WORD)) || (state_q == RMW_WRITE);
    MemAddress   = (state_q == IDLE) ? 16'd0 : addr_q;
    MemWriteData = 16'd0;
    if (state_q == RMW_WRITE) begin
      MemWriteData = merged_word;
    end else if ((state_q == ACCESS) && (acc_q == ACC_STORE_WORD)) begin
      MemWriteData = wdata_q;
    end
    RspValid = rsp_vld_q;
    RspData  = rsp_data_q;
    RspFault = rsp_fault_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: directed, table-driven check of load_store_unit against a byte-array memory model.
// Latency: measured per request from the accepting edge to the first visible RspValid.
// Backpressure: requests are only driven once ReqReady is seen at the falling edge.
module tb_load_store_unit;

  logic        Clock;
  logic        Reset_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic        ReqByte;
  logic        ReqSigned;
  logic [15:0] ReqAddr;
  logic [15:0] ReqWData;
  logic        RspValid;
  logic [15:0] RspData;
  logic        RspFault;
  logic [15:0] MemAddress;
  logic [15:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] MemReadData;

  logic [7:0] mem [0:127];
  int wr_cnt;
  int rd_cnt;
  int errors;
  int checks;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqByte      (ReqByte),
    .ReqSigned    (ReqSigned),
    .ReqAddr      (ReqAddr),
    .ReqWData     (ReqWData),
    .RspValid     (RspValid),
    .RspData      (RspData),
    .RspFault     (RspFault),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Big-endian combinational read port.
  assign MemReadData = {mem[MemAddress[6:0]], mem[MemAddress[6:0] + 7'd1]};

  // Memory write port and strobe counters.
  always @(posedge Clock) begin
    if (MemWrite) begin
      mem[MemAddress[6:0]]         = MemWriteData[15:8];
      mem[MemAddress[6:0] + 7'd1]  = MemWriteData[7:0];
      wr_cnt = wr_cnt + 1;
    end
    if (MemRead) rd_cnt = rd_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic        byt;
    logic        sgn;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_fault;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic wr, input logic byt, input logic sgn,
                     input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] exp_data,
                     input logic exp_fault, input int exp_lat, input int exp_rd, input int exp_wr);
    vec_t v;
    v.name = name; v.wr = wr; v.byt = byt; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    vq.push_back(v);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge Clock);
    while (!ReqReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (!ReqReady) begin
      errors = errors + 1;
      checks = checks + 1;
      $display("FAIL wait_ready: ReqReady stuck low");
    end
  endtask

  task automatic drive(input logic wr, input logic byt, input logic sgn,
                       input logic [15:0] addr, input logic [15:0] wdata);
    ReqValid  = 1'b1;
    ReqWrite  = wr;
    ReqByte   = byt;
    ReqSigned = sgn;
    ReqAddr   = addr;
    ReqWData  = wdata;
  endtask

  logic [15:0] bb_addr [3];
  logic        bb_byte [3];
  logic [15:0] bb_exp  [3];

  initial begin
    int lat;
    int rd0;
    int wr0;
    int idx;
    int nrsp;
    int cyc;
    errors = 0; checks = 0; wr_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hAB; mem[8'h11] = 8'hCD; mem[8'h12] = 8'h99;
    mem[8'h20] = 8'h80; mem[8'h21] = 8'h11;
    mem[8'h30] = 8'h12; mem[8'h31] = 8'h34;
    mem[8'h40] = 8'h7F; mem[8'h41] = 8'h00;
    mem[8'h60] = 8'h11; mem[8'h61] = 8'h22;
    mem[8'h7E] = 8'h5A; mem[8'h7F] = 8'hA5;
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqByte = 1'b0; ReqSigned = 1'b0;
    ReqAddr = 16'd0; ReqWData = 16'd0;

    // Reset state, checked while reset is held.
    Reset_n = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_rspvalid", {31'd0, RspValid}, 32'd0);
    chk("rst_rspdata", {16'd0, RspData}, 32'd0);
    chk("rst_rspfault", {31'd0, RspFault}, 32'd0);
    chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rst_memread", {31'd0, MemRead}, 32'd0);
    chk("rst_memaddr", {16'd0, MemAddress}, 32'd0);
    chk("rst_memwdata", {16'd0, MemWriteData}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rst_reqready", {31'd0, ReqReady}, 32'd1);

    //   name          wr    byt   sgn   addr      wdata     exp_data  flt   lat rd wr
    add("lw_10",       1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hABCD, 1'b0, 2, 1, 0);
    add("lbs_20",      1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 16'hFF80, 1'b0, 2, 1, 0);
    add("lbu_20",      1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0080, 1'b0, 2, 1, 0);
    add("lbs_40",      1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'h007F, 1'b0, 2, 1, 0);
    add("sw_50",       1'b1, 1'b0, 1'b0, 16'h0050, 16'hBEEF, 16'h0000, 1'b0, 2, 0, 1);
    add("lw_50",       1'b0, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'hBEEF, 1'b0, 2, 1, 0);
    add("sb_30",       1'b1, 1'b1, 1'b0, 16'h0030, 16'h00EE, 16'h0000, 1'b0, 3, 1, 1);
    add("lw_30",       1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'hEE34, 1'b0, 2, 1, 0);
    add("sw_7f_flt",   1'b1, 1'b0, 1'b0, 16'h007F, 16'h1234, 16'h0000, 1'b1, 1, 0, 0);
    add("sb_7f_flt",   1'b1, 1'b1, 1'b0, 16'h007F, 16'h0055, 16'h0000, 1'b1, 1, 0, 0);
    add("lw_7e_edge",  1'b0, 1'b0, 1'b0, 16'h007E, 16'h0000, 16'h5AA5, 1'b0, 2, 1, 0);
    add("lw_ffff_flt", 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1, 0, 0);
    add("lw_80_flt",   1'b0, 1'b0, 1'b0, 16'h0080, 16'h0000, 16'h0000, 1'b1, 1, 0, 0);
    add("lbu_11_odd",  1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 16'h00CD, 1'b0, 2, 1, 0);
`ifdef LSU_ALIGN_CHECK_EN
    add("lw_11_odd",   1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 1, 0, 0);
`else
    add("lw_11_odd",   1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'hCD99, 1'b0, 2, 1, 0);
`endif

    foreach (vq[i]) begin
      wait_ready();
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      drive(vq[i].wr, vq[i].byt, vq[i].sgn, vq[i].addr, vq[i].wdata);
      @(posedge Clock);
      #1;
      ReqValid = 1'b0;
      lat = 1;
      while (!RspValid && lat < 10) begin
        @(posedge Clock);
        #1;
        lat++;
      end
      chk({vq[i].name, "_lat"}, lat, vq[i].exp_lat);
      chk({vq[i].name, "_data"}, {16'd0, RspData}, {16'd0, vq[i].exp_data});
      chk({vq[i].name, "_fault"}, {31'd0, RspFault}, {31'd0, vq[i].exp_fault});
      @(posedge Clock);
      #1;
      chk({vq[i].name, "_pulse"}, {31'd0, RspValid}, 32'd0);
      chk({vq[i].name, "_rdcnt"}, rd_cnt - rd0, vq[i].exp_rd);
      chk({vq[i].name, "_wrcnt"}, wr_cnt - wr0, vq[i].exp_wr);
    end

    // Byte store must have preserved the neighbouring byte.
    chk("sb_mem30", {24'd0, mem[8'h30]}, 32'h0000_00EE);
    chk("sb_mem31", {24'd0, mem[8'h31]}, 32'h0000_0034);
    chk("flt_mem7f", {24'd0, mem[8'h7F]}, 32'h0000_00A5);

    // Reset asserted during RMW_WRITE aborts the byte store.
    wait_ready();
    wr0 = wr_cnt;
    drive(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0077);
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    @(posedge Clock);
    #1;
    chk("rmw_in_write", {31'd0, MemWrite}, 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rmw_rst_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rmw_rst_memaddr", {16'd0, MemAddress}, 32'd0);
    @(posedge Clock);
    #1;
    chk("rmw_rst_rspvalid", {31'd0, RspValid}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rmw_rst_ready", {31'd0, ReqReady}, 32'd1);
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      if (RspValid) cyc++;
    end
    chk("rmw_rst_norsp", cyc, 0);
    chk("rmw_rst_wrcnt", wr_cnt - wr0, 0);
    chk("rmw_rst_mem60", {24'd0, mem[8'h60]}, 32'h0000_0011);
    chk("rmw_rst_mem61", {24'd0, mem[8'h61]}, 32'h0000_0022);

    // Back-to-back: ReqValid held high across three requests.
    bb_addr[0] = 16'h0010; bb_byte[0] = 1'b0; bb_exp[0] = 16'hABCD;
    bb_addr[1] = 16'h0021; bb_byte[1] = 1'b1; bb_exp[1] = 16'h0011;
    bb_addr[2] = 16'h0030; bb_byte[2] = 1'b0; bb_exp[2] = 16'hEE34;
    idx = 0;
    nrsp = 0;
    cyc = 0;
    @(negedge Clock);
    drive(1'b0, bb_byte[0], 1'b0, bb_addr[0], 16'h0000);
    while (nrsp < 3 && cyc < 60) begin
      if (RspValid) begin
        chk($sformatf("b2b_data%0d", nrsp), {16'd0, RspData}, {16'd0, bb_exp[nrsp]});
        nrsp++;
      end
      if (idx < 3) begin
        drive(1'b0, bb_byte[idx], 1'b0, bb_addr[idx], 16'h0000);
        if (ReqReady) begin
          chk($sformatf("b2b_inorder%0d", idx), nrsp, idx);
          idx++;
        end
      end else begin
        ReqValid = 1'b0;
      end
      @(negedge Clock);
      cyc++;
    end
    ReqValid = 1'b0;
    chk("b2b_rsp_count", nrsp, 3);
    chk("b2b_accept_count", idx, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
